// File: rtl/sctag_vuad_acc_if.sv
// Request/grant and datapath-control bundle between the VUAD requesters and the access controller.
// Handshake: a requester raises *_req with stable *_wr/*_ua and holds them until the cycle
// its *_gnt is 1; the grant is combinational, so the access is accepted in that same cycle.
interface sctag_vuad_acc_if;
    logic       arb_stall_c1;
    logic       diag_req;
    logic       diag_wr;
    logic       diag_ua;
    logic       bist_req;
    logic       bist_wr;
    logic       bist_ua;
    logic [3:0] vuad_syndrome_c9;
    logic       diag_gnt;
    logic       bist_gnt;
    logic       arbctl_acc_ua_c2;
    logic       ua_wr_en_c3;
    logic       vd_wr_en_c3;
    logic       sel_diag1_data_wr_c3;
    logic       sel_diag0_data_wr_c3;
    logic       diag_rd_vld_c8;
    logic       bist_rd_vld_c8;
    logic       vuad_par_err_c9;
    logic       par_err_bist_c9;
    logic       busy;

    modport master (
        output arb_stall_c1, diag_req, diag_wr, diag_ua, bist_req, bist_wr, bist_ua,
               vuad_syndrome_c9,
        input  diag_gnt, bist_gnt, arbctl_acc_ua_c2, ua_wr_en_c3, vd_wr_en_c3,
               sel_diag1_data_wr_c3, sel_diag0_data_wr_c3, diag_rd_vld_c8, bist_rd_vld_c8,
               vuad_par_err_c9, par_err_bist_c9, busy
    );

    modport slave (
        input  arb_stall_c1, diag_req, diag_wr, diag_ua, bist_req, bist_wr, bist_ua,
               vuad_syndrome_c9,
        output diag_gnt, bist_gnt, arbctl_acc_ua_c2, ua_wr_en_c3, vd_wr_en_c3,
               sel_diag1_data_wr_c3, sel_diag0_data_wr_c3, diag_rd_vld_c8, bist_rd_vld_c8,
               vuad_par_err_c9, par_err_bist_c9, busy
    );
endinterface

// File: rtl/sctag_vuad_acc_ctl.sv
// VUAD diag/BIST access controller: round-robin arbitration with write->read hazard blocking,
// an 8-stage C2..C9 op tracker, and datapath select/strobe/read-valid/parity generation.
module sctag_vuad_acc_ctl #(
    parameter int DW      = 26,
    parameter int HAZ_CYC = 2
) (
    input logic                  rclk,
    input logic                  arst_l,
    sctag_vuad_acc_if.slave      bus
);
    localparam int HW = (HAZ_CYC < 1) ? 1 : $clog2(HAZ_CYC + 1);

    // Stage index 0 is C2, index 7 is C9.
    logic [7:0]    vld_q, vld_d, own_q, own_d, wr_q, wr_d, ua_q, ua_d;
    logic          last_bist_q, last_bist_d;
    logic [HW-1:0] haz_ua_q, haz_ua_d, haz_vd_q, haz_vd_d;
    logic          acc_ua_q, acc_ua_d;
    logic          ua_wr_q, ua_wr_d, vd_wr_q, vd_wr_d;
    logic          sel1_q, sel1_d, sel0_q, sel0_d;
    logic          diag_elig, bist_elig, diag_gnt, bist_gnt;
    logic          gnt_wr, gnt_ua, c2_wr, c9_rd;

    always_comb begin
        diag_elig = bus.diag_req && !bus.arb_stall_c1 &&
                    (bus.diag_wr || (bus.diag_ua ? (haz_ua_q == '0) : (haz_vd_q == '0)));
        bist_elig = bus.bist_req && !bus.arb_stall_c1 &&
                    (bus.bist_wr || (bus.bist_ua ? (haz_ua_q == '0) : (haz_vd_q == '0)));
        diag_gnt  = diag_elig && (!bist_elig || last_bist_q);
        bist_gnt  = bist_elig && (!diag_elig || !last_bist_q);
        gnt_wr    = bist_gnt ? bus.bist_wr : bus.diag_wr;
        gnt_ua    = bist_gnt ? bus.bist_ua : bus.diag_ua;
    end

    always_comb begin
        vld_d = {vld_q[6:0], diag_gnt | bist_gnt};
        own_d = {own_q[6:0], bist_gnt};
        wr_d  = {wr_q[6:0], gnt_wr};
        ua_d  = {ua_q[6:0], gnt_ua};

        last_bist_d = last_bist_q;
        if (diag_gnt) last_bist_d = 1'b0;
        if (bist_gnt) last_bist_d = 1'b1;

        haz_ua_d = (haz_ua_q != '0) ? haz_ua_q - 1'b1 : '0;
        haz_vd_d = (haz_vd_q != '0) ? haz_vd_q - 1'b1 : '0;
        if ((diag_gnt || bist_gnt) && gnt_wr) begin
            if (gnt_ua) haz_ua_d = HW'(HAZ_CYC);
            else        haz_vd_d = HW'(HAZ_CYC);
        end

        // The C3 strobes/selects are registered from what sits in C2.
        c2_wr   = vld_q[0] && wr_q[0];
        ua_wr_d = c2_wr && ua_q[0];
        vd_wr_d = c2_wr && !ua_q[0];
        sel1_d  = (c2_wr && ua_q[0])  ? !own_q[0] : sel1_q;
        sel0_d  = (c2_wr && !ua_q[0]) ? !own_q[0] : sel0_q;

        acc_ua_d = (vld_q[0] && !wr_q[0]) ? ua_q[0] : acc_ua_q;
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            vld_q       <= '0;
            own_q       <= '0;
            wr_q        <= '0;
            ua_q        <= '0;
            last_bist_q <= 1'b1;
            haz_ua_q    <= '0;
            haz_vd_q    <= '0;
            acc_ua_q    <= 1'b0;
            ua_wr_q     <= 1'b0;
            vd_wr_q     <= 1'b0;
            sel1_q      <= 1'b0;
            sel0_q      <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            own_q       <= own_d;
            wr_q        <= wr_d;
            ua_q        <= ua_d;
            last_bist_q <= last_bist_d;
            haz_ua_q    <= haz_ua_d;
            haz_vd_q    <= haz_vd_d;
            acc_ua_q    <= acc_ua_d;
            ua_wr_q     <= ua_wr_d;
            vd_wr_q     <= vd_wr_d;
            sel1_q      <= sel1_d;
            sel0_q      <= sel0_d;
        end
    end

    always_comb begin
        c9_rd = vld_q[7] && !wr_q[7];
        bus.diag_gnt             = diag_gnt;
        bus.bist_gnt             = bist_gnt;
        bus.arbctl_acc_ua_c2     = acc_ua_d;
        bus.ua_wr_en_c3          = ua_wr_q;
        bus.vd_wr_en_c3          = vd_wr_q;
        bus.sel_diag1_data_wr_c3 = sel1_q;
        bus.sel_diag0_data_wr_c3 = sel0_q;
        bus.diag_rd_vld_c8       = vld_q[6] && !wr_q[6] && !own_q[6];
        bus.bist_rd_vld_c8       = vld_q[6] && !wr_q[6] && own_q[6];
        // UA parity lives in syndrome[1:0], VD parity in syndrome[3:2].
        bus.vuad_par_err_c9      = c9_rd && (ua_q[7] ? (|bus.vuad_syndrome_c9[1:0])
                                                     : (|bus.vuad_syndrome_c9[3:2]));
        bus.par_err_bist_c9      = bus.vuad_par_err_c9 && own_q[7];
        bus.busy                 = |vld_q;
    end

    if (DW < 4) begin : g_dw_chk
        $error("DW must cover the four VUAD bits");
    end

    gnt_onehot_a: assert property (@(posedge rclk) disable iff (!arst_l)
        !(diag_gnt && bist_gnt));
endmodule
